// File: rtl/data_bus_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller and memory.
// The controller side drives the request; the memory side answers with addr_ok/data_ok.
interface data_bus_ctrl_if;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/data_bus_ctrl.sv
// MEM-stage data bus controller: converts a held pipeline access into a single
// outstanding addr_ok/data_ok memory transaction and stalls the pipeline until it completes.
module data_bus_ctrl (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_en,
  input  logic [3:0]      core_wen,
  input  logic [31:0]     core_addr,
  input  logic [31:0]     core_wdata,
  input  logic            core_flush,
  output logic [31:0]     core_rdata,
  output logic            core_stall,
  data_bus_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        cancel_reg, cancel_next;
  logic [3:0]  wen_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        load_hold;
  logic        load_rdata;
  logic [1:0]  size_next;
  logic [3:0]  wstrb_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cancel_reg <= 1'b0;
      wen_reg    <= 4'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cancel_reg <= cancel_next;
      if (load_hold) begin
        wen_reg   <= core_wen;
        addr_reg  <= core_addr;
        wdata_reg <= core_wdata;
      end
      if (load_rdata) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cancel_next = cancel_reg;
    load_hold   = 1'b0;
    load_rdata  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (core_en && !core_flush) begin
          load_hold  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.mem_addr_ok) begin
          if (bus.mem_data_ok) begin
            // A flush arriving with the completion discards the result.
            if (core_flush) begin
              state_next = IDLE;
            end else begin
              load_rdata = 1'b1;
              state_next = DONE;
            end
          end else begin
            cancel_next = core_flush;
            state_next  = WAIT;
          end
        end else if (core_flush) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (core_flush) begin
          cancel_next = 1'b1;
        end
        if (bus.mem_data_ok) begin
          cancel_next = 1'b0;
          if (cancel_reg || core_flush) begin
            state_next = IDLE;
          end else begin
            load_rdata = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Contiguous halves are half-word accesses, lone bytes are byte accesses,
  // everything else (including loads) goes out as a full word.
  always_comb begin
    size_next = 2'd2;
    case (wen_reg)
      4'b0011, 4'b1100:                   size_next = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_next = 2'd0;
      default:                            size_next = 2'd2;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
      assign wstrb_next[gi] = wen_reg[gi];
    end
  endgenerate

  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_wr    = |wen_reg;
  assign bus.mem_size  = size_next;
  assign bus.mem_wstrb = wstrb_next;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign core_rdata = rdata_reg;
  assign core_stall = !rst && (((state_reg == IDLE) && core_en && !core_flush) ||
                               (state_reg == REQ) || (state_reg == WAIT));

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: the bench plays both pipeline and memory,
// and every expectation below is hand-computed.
module tb_data_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_en;
  logic [3:0]  core_wen;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_flush;
  logic [31:0] core_rdata;
  logic        core_stall;

  int checks = 0;
  int errors = 0;

  data_bus_ctrl_if bus ();

  data_bus_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .core_en    (core_en),
    .core_wen   (core_wen),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_flush (core_flush),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    core_en = 1'b1;
    step;
    step;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", core_stall); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", bus.mem_req); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", core_rdata); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", bus.mem_addr); end
    core_en = 1'b0;
    rst = 1'b0;
    step;
    $display("txn reset done");
  endtask

  task automatic test_load;
    int stalls;
    stalls = 0;
    core_en = 1'b1; core_wen = 4'b0000; core_addr = 32'hBFC0_0100;
    #1; if (core_stall) stalls++;
    step;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL load_req got=%0b exp=1", bus.mem_req); end
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL load_wr got=%0b exp=0", bus.mem_wr); end
    checks++; if (bus.mem_size !== 2'd2) begin errors++; $display("FAIL load_size got=%0d exp=2", bus.mem_size); end
    checks++; if (bus.mem_wstrb !== 4'b0000) begin errors++; $display("FAIL load_wstrb got=%b exp=0000", bus.mem_wstrb); end
    checks++; if (bus.mem_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL load_addr got=%h exp=bfc00100", bus.mem_addr); end
    if (core_stall) stalls++;
    bus.mem_addr_ok = 1'b1;
    step;
    bus.mem_addr_ok = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL load_wait_req got=%0b exp=0", bus.mem_req); end
    if (core_stall) stalls++;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1234_5678;
    step;
    bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL load_done_stall got=%0b exp=0", core_stall); end
    checks++; if (core_rdata !== 32'h1234_5678) begin errors++; $display("FAIL load_rdata got=%h exp=12345678", core_rdata); end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL load_stall_cycles got=%0d exp=3", stalls); end
    $display("txn load addr=bfc00100 rdata=%h stall_cycles=%0d", core_rdata, stalls);
    core_en = 1'b0;
    step;
  endtask

  task automatic test_store;
    core_en = 1'b1; core_wen = 4'b0100; core_addr = 32'h8000_0002; core_wdata = 32'h00AB_0000;
    step;
    core_addr = 32'h0; core_wdata = 32'h0;
    checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL store_wr got=%0b exp=1", bus.mem_wr); end
    checks++; if (bus.mem_size !== 2'd0) begin errors++; $display("FAIL store_size got=%0d exp=0", bus.mem_size); end
    checks++; if (bus.mem_wstrb !== 4'b0100) begin errors++; $display("FAIL store_wstrb got=%b exp=0100", bus.mem_wstrb); end
    checks++; if (bus.mem_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL store_wdata got=%h exp=00ab0000", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h8000_0002) begin errors++; $display("FAIL store_addr got=%h exp=80000002", bus.mem_addr); end
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    step;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL store_done_stall got=%0b exp=0", core_stall); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL store_done_req got=%0b exp=0", bus.mem_req); end
    $display("txn store addr=80000002 wstrb=0100 wdata=00ab0000");
    core_en = 1'b0;
    step;
  endtask

  task automatic test_size_table;
    logic [3:0] pats [6];
    logic [1:0] sizes [6];
    logic       wrs [6];
    pats  = '{4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0101, 4'b0000};
    sizes = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
    wrs   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      core_en = 1'b1; core_wen = pats[i]; core_addr = 32'h100 + 32'(i * 4);
      step;
      checks++; if (bus.mem_size !== sizes[i]) begin errors++; $display("FAIL size_%b got=%0d exp=%0d", pats[i], bus.mem_size, sizes[i]); end
      checks++; if (bus.mem_wr !== wrs[i]) begin errors++; $display("FAIL wr_%b got=%0b exp=%0b", pats[i], bus.mem_wr, wrs[i]); end
      // Flush while the request is still unaccepted.
      core_flush = 1'b1;
      step;
      core_flush = 1'b0; core_en = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_req_drop_%b got=%0b exp=0", pats[i], bus.mem_req); end
      core_en = 1'b1;
      #1;
      checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL flush_req_idle_%b got=%0b exp=1", pats[i], core_stall); end
      core_en = 1'b0;
      $display("txn size wen=%b size=%0d flushed_in_req", pats[i], bus.mem_size);
      step;
    end
  endtask

  task automatic test_addr_hold;
    core_en = 1'b1; core_wen = 4'b0000; core_addr = 32'hA000_0000;
    step;
    for (int i = 0; i < 5; i++) begin
      core_addr = 32'h5555_0000 + 32'(i);
      #1;
      checks++; if (bus.mem_addr !== 32'hA000_0000) begin errors++; $display("FAIL hold_addr_%0d got=%h exp=a0000000", i, bus.mem_addr); end
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL hold_req_%0d got=%0b exp=1", i, bus.mem_req); end
      checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d got=%0b exp=1", i, core_stall); end
      step;
    end
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    checks++; if (core_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_rdata got=%h exp=cafef00d", core_rdata); end
    $display("txn load addr=a0000000 after 5 refused cycles rdata=%h", core_rdata);
    core_en = 1'b0;
    step;
  endtask

  task automatic test_flush_wait;
    core_en = 1'b1; core_wen = 4'b0000; core_addr = 32'h1000_0000;
    step;
    bus.mem_addr_ok = 1'b1;
    step;
    bus.mem_addr_ok = 1'b0; core_flush = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fwait_req got=%0b exp=0", bus.mem_req); end
    step;
    core_flush = 1'b0; core_en = 1'b0;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL fwait_still_waiting got=%0b exp=1", core_stall); end
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    step;
    bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    checks++; if (core_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL fwait_rdata got=%h exp=cafef00d", core_rdata); end
    core_en = 1'b1;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL fwait_idle_not_done got=%0b exp=1", core_stall); end
    core_en = 1'b0;
    $display("txn load addr=10000000 flushed_in_wait rdata_kept=%h", core_rdata);
    step;
  endtask

  task automatic test_reset_in_wait;
    core_en = 1'b1; core_wen = 4'b0000; core_addr = 32'h2000_0000;
    step;
    bus.mem_addr_ok = 1'b1;
    step;
    bus.mem_addr_ok = 1'b0; rst = 1'b1;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rwait_stall_in_rst got=%0b exp=0", core_stall); end
    step;
    rst = 1'b0; core_en = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #1;
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL rwait_rdata_cleared got=%h exp=00000000", core_rdata); end
    step;
    bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL rwait_late_data got=%h exp=00000000", core_rdata); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rwait_req got=%0b exp=0", bus.mem_req); end
    core_en = 1'b1;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rwait_idle_not_done got=%0b exp=1", core_stall); end
    core_en = 1'b0;
    $display("txn load addr=20000000 reset_in_wait rdata=%h", core_rdata);
    step;
  endtask

  task automatic test_back_to_back;
    int acc;
    int dn;
    logic [31:0] exp_rdata;
    acc = 0; dn = 0;
    core_en = 1'b1; core_wen = 4'b0000; core_addr = 32'h0000_1000;
    for (int c = 0; c < 20 && dn < 2; c++) begin
      bus.mem_addr_ok = bus.mem_req;
      bus.mem_data_ok = bus.mem_req;
      bus.mem_rdata   = (bus.mem_addr == 32'h0000_1000) ? 32'h5A5A_1000 : 32'h5A5A_2000;
      #1;
      if (bus.mem_req && bus.mem_addr_ok) acc++;
      if (!core_stall) begin
        exp_rdata = (dn == 0) ? 32'h5A5A_1000 : 32'h5A5A_2000;
        checks++; if (core_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata_%0d got=%h exp=%h", dn, core_rdata, exp_rdata); end
        $display("txn b2b load %0d rdata=%h", dn, core_rdata);
        dn++;
        core_addr = 32'h0000_2000;
        if (dn == 2) core_en = 1'b0;
      end
      step;
    end
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_dup_req_%0d got=%0b exp=0", c, bus.mem_req); end
      step;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_acceptances got=%0d exp=2", acc); end
    checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", dn); end
  endtask

  initial begin
    rst = 1'b1; core_en = 1'b0; core_wen = 4'b0000; core_addr = 32'h0;
    core_wdata = 32'h0; core_flush = 1'b0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    test_reset;
    test_load;
    test_store;
    test_size_table;
    test_addr_hold;
    test_flush_wait;
    test_reset_in_wait;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
